pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline-control unit for the in-order CPU. Replaces the fixed two-stage (EX/MEM) hazard detector.
- Keeps a per-stage scoreboard of in-flight destination registers over DEPTH post-ID stages.
- Produces stall, flush and forwarding selects, and runs a halt/drain/program-switch FSM.
- Optional saturating performance counters for stall and flush cycles.

Parameters:
- DEPTH, 3: post-ID stages tracked; entry 0 = EX, entry DEPTH-1 = WB; legal range 2..6.
- REG_AW, 5: register address width.
- FWD_EN, 1: 1 = forwarding with load-use stall only; 0 = stall on any RAW hazard.
- CNT_W, 16: performance counter width.
- SELW, 3: forwarding select width; must satisfy 2^SELW >= DEPTH.

Ports:
- clk  in  1  clock
- rst  in  1  async reset, active low
- id_valid  in  1  ID holds a real instruction
- id_rs  in  REG_AW  ID source register rs
- id_rt  in  REG_AW  ID source register rt
- id_rs_read  in  1  ID reads rs
- id_rt_read  in  1  ID reads rt
- id_dst  in  REG_AW  ID destination register
- id_reg_wen  in  1  ID writes a register
- id_is_load  in  1  ID instruction is a load
- change_flow  in  1  EX redirect (jump, taken branch, mispredict)
- halt_req  in  1  halt instruction fetched in IF
- switch_program  in  1  load new program (SPART)
- ext_stall  in  1  memory not ready; freeze the pipeline
- stall_pc  out  1  hold PC
- stall_id  out  1  hold the IF/ID register
- flush_id  out  1  zero the IF/ID register
- flush_ex  out  1  bubble the ID/EX register
- fwd_rs_sel  out  SELW  0 = register file; k = result of scoreboard entry k-1
- fwd_rt_sel  out  SELW  same encoding as fwd_rs_sel
- pipe_valid  out  DEPTH  scoreboard valid bits
- halted  out  1  FSM in HALTED
- stall_cnt  out  CNT_W  cycles with stall_id=1, saturating
- flush_cnt  out  CNT_W  cycles with flush_ex=1, saturating

Behaviour:
- Reset (async, rst=0): scoreboard cleared, FSM=RUN, both counters 0. All outputs 0 except while RUN with an empty pipe (every control output 0).
- Scoreboard entry fields: {valid, dst, wen, load}.
- Scoreboard update, each clk with ext_stall=0:
  - entry k <= entry k-1.
  - entry 0 <= ID instruction when issue=1, else a bubble (valid=0).
  - issue = id_valid & ~stall_id & ~flush_ex.
- ext_stall=1: scoreboard and FSM hold. stall_pc=stall_id=1, flush_id=flush_ex=0. Counters do not increment.
- Match rule for source s (rs or rt): entry k matches when valid & wen & dst==s & s!=0 & read-enable, with k in 0..DEPTH-2. WB (entry DEPTH-1) is covered by the register file write-through, so it never matches.
- FWD_EN=0:
  - raw = any match on rs or rt.
  - fwd_*_sel are always 0.
- FWD_EN=1:
  - raw = entry 0 matches and entry 0 is a load.
  - fwd_*_sel = k+1 for the youngest (lowest k) matching entry, else 0.
  - Forwarding selects are combinational and valid in the same cycle.
- Hazard stall: stall_pc=stall_id=raw, flush_ex=raw (bubble injected into EX).
- Redirect: change_flow=1 (with ext_stall=0) gives flush_id=1, flush_ex=1, stall_pc=0, stall_id=0. A redirect overrides any simultaneous RAW stall.
- FSM states: RUN, DRAIN, HALTED.
  - RUN: halt_req & ~change_flow -> DRAIN.
  - DRAIN: stall_pc=1 and flush_id=1 (no new issue). change_flow -> RUN, discarding the halt as wrong-path. When pipe_valid==0 -> HALTED.
  - HALTED: stall_pc=1, flush_id=1, halted=1. switch_program -> RUN on the next cycle.
  - switch_program in RUN or DRAIN: flush_id=1, flush_ex=1; state -> RUN.
  - Simultaneous halt_req and switch_program: switch_program wins.
- Counters:
  - stall_cnt increments each cycle with stall_id=1 & ext_stall=0.
  - flush_cnt increments each cycle with flush_ex=1.
  - Both saturate at 2^CNT_W-1. Reset mid-operation clears the counters and the scoreboard immediately.

Decomposition:
- Shared package cpu_pkg:
  - FSM state enum (RUN, DRAIN, HALTED).
  - Scoreboard entry struct {valid, dst, wen, load}.
  - REG_AW default and the forwarding-select encoding constants FWD_RF=0.
- One sub-module, sb_match: combinational priority matcher giving a youngest-match index and a hit flag per source. Instantiated twice, once for rs and once for rt.

Test Plan:
- Test 1, FWD_EN=1, DEPTH=3. Issue "add r3" then "sub r4,r3" back-to-back -> sub in ID sees fwd_rs_sel=1, no stall. One cycle later, consumer of r3 -> fwd_rs_sel=2.
- Test 2, FWD_EN=1. "lw r5" followed by "add r6,r5" -> stall_id=stall_pc=flush_ex=1 for exactly 1 cycle, then fwd_rs_sel=1, stall_cnt=1.
- Test 3, FWD_EN=0, DEPTH=4. Producer r7 followed by consumer r7 -> stall for 3 cycles; fwd_*_sel stay 0. Consumer of r0 never stalls.
- Test 4: RAW stall and change_flow in the same cycle -> flush_id=flush_ex=1, stall_id=0, flush_cnt increments by 1.
- Test 5: halt_req with 3 instructions in flight -> DRAIN. halted=1 is asserted the cycle after pipe_valid reaches 0. switch_program pulse -> RUN next cycle, halted=0.
- Test 6: ext_stall held for 5 cycles mid-hazard -> scoreboard and counters frozen. Assert rst=0 during DRAIN -> all outputs 0, FSM=RUN, pipe_valid=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline-control types for the in-order CPU: hazard FSM states,
// scoreboard entry layout and forwarding-select encoding.
package cpu_pkg;

  localparam int REG_AW_DEF = 5;
  // Scoreboard entries carry the widest supported register address; narrower
  // register files zero-extend into it.
  localparam int REG_AW_MAX = 8;

  // Forwarding select value meaning "take the register-file operand".
  localparam int FWD_RF = 0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_MAX-1:0] dst;
    logic                  wen;
    logic                  load;
  } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Youngest-match finder over the in-flight scoreboard for one source operand.
// The WB entry never matches: the register file writes through to ID.
module sb_match
  import cpu_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int SELW  = 3
) (
  input  sb_entry_t [DEPTH-1:0] sb,
  input  logic [REG_AW_MAX-1:0] src,
  input  logic                  rd_en,
  output logic                  hit,
  output logic [SELW-1:0]       idx
);

  logic [DEPTH-1:0] match_s;

  // per-entry producer match against the requested source register
  always_comb begin
    match_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((k != DEPTH - 1) && sb[k].valid && sb[k].wen &&
          (sb[k].dst == src) && (|src) && rd_en) begin
        match_s[k] = 1'b1;
      end else begin
        match_s[k] = 1'b0;
      end
    end
  end

  // scan oldest to youngest so the lowest index is the one left standing
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      hit = hit | match_s[k];
      idx = match_s[k] ? SELW'(k) : idx;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: in-flight destination scoreboard, RAW stall / redirect
// flush / forwarding selects, halt-drain-switch FSM and saturating counters.
module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int REG_AW = REG_AW_DEF,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16,
  parameter int SELW   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_read,
  input  logic              id_rt_read,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_reg_wen,
  input  logic              id_is_load,
  input  logic              change_flow,
  input  logic              halt_req,
  input  logic              switch_program,
  input  logic              ext_stall,
  output logic              stall_pc,
  output logic              stall_id,
  output logic              flush_id,
  output logic              flush_ex,
  output logic [SELW-1:0]   fwd_rs_sel,
  output logic [SELW-1:0]   fwd_rt_sel,
  output logic [DEPTH-1:0]  pipe_valid,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  sb_entry_t [DEPTH-1:0] sb_r;
  sb_entry_t             id_entry_s;
  hz_state_e             state_r;
  hz_state_e             state_nxt_s;

  logic [REG_AW_MAX-1:0] rs_ext_s;
  logic [REG_AW_MAX-1:0] rt_ext_s;
  logic                  rs_hit_s;
  logic                  rt_hit_s;
  logic [SELW-1:0]       rs_idx_s;
  logic [SELW-1:0]       rt_idx_s;
  logic                  load_use_s;
  logic                  raw_s;
  logic                  issue_s;
  logic                  pipe_empty_s;
  logic [CNT_W-1:0]      stall_cnt_r;
  logic [CNT_W-1:0]      flush_cnt_r;

  assign rs_ext_s = REG_AW_MAX'(id_rs);
  assign rt_ext_s = REG_AW_MAX'(id_rt);

  sb_match #(.DEPTH(DEPTH), .SELW(SELW)) u_match_rs (
    .sb    (sb_r),
    .src   (rs_ext_s),
    .rd_en (id_rs_read),
    .hit   (rs_hit_s),
    .idx   (rs_idx_s)
  );

  sb_match #(.DEPTH(DEPTH), .SELW(SELW)) u_match_rt (
    .sb    (sb_r),
    .src   (rt_ext_s),
    .rd_en (id_rt_read),
    .hit   (rt_hit_s),
    .idx   (rt_idx_s)
  );

  // With forwarding only a load still in EX is a hazard; without it any match is
  always_comb begin
    load_use_s = sb_r[0].load &
                 ((rs_hit_s & (rs_idx_s == '0)) | (rt_hit_s & (rt_idx_s == '0)));
    if (FWD_EN != 0) begin
      raw_s = load_use_s;
    end else begin
      raw_s = rs_hit_s | rt_hit_s;
    end
  end

  // forwarding selects: entry k is encoded as k+1, zero means register file
  always_comb begin
    fwd_rs_sel = SELW'(FWD_RF);
    fwd_rt_sel = SELW'(FWD_RF);
    if (FWD_EN != 0) begin
      fwd_rs_sel = rs_hit_s ? (rs_idx_s + SELW'(1)) : SELW'(FWD_RF);
      fwd_rt_sel = rt_hit_s ? (rt_idx_s + SELW'(1)) : SELW'(FWD_RF);
    end else begin
      fwd_rs_sel = SELW'(FWD_RF);
      fwd_rt_sel = SELW'(FWD_RF);
    end
  end

  // pipeline control outputs and FSM next state
  always_comb begin
    stall_pc    = 1'b0;
    stall_id    = 1'b0;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;
    state_nxt_s = state_r;
    if (ext_stall) begin
      stall_pc = 1'b1;
      stall_id = 1'b1;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (switch_program || change_flow) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
          end else if (raw_s) begin
            stall_pc = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
          end else begin
            stall_pc = 1'b0;
          end
          if (switch_program) begin
            state_nxt_s = ST_RUN;
          end else if (halt_req && !change_flow) begin
            state_nxt_s = ST_DRAIN;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_DRAIN: begin
          stall_pc = 1'b1;
          flush_id = 1'b1;
          if (switch_program) begin
            flush_ex    = 1'b1;
            state_nxt_s = ST_RUN;
          end else if (change_flow) begin
            // the halt was on the wrong path: redirect and resume
            stall_pc    = 1'b0;
            flush_ex    = 1'b1;
            state_nxt_s = ST_RUN;
          end else begin
            stall_id    = raw_s;
            flush_ex    = raw_s;
            state_nxt_s = pipe_empty_s ? ST_HALTED : ST_DRAIN;
          end
        end
        ST_HALTED: begin
          stall_pc    = 1'b1;
          flush_id    = 1'b1;
          state_nxt_s = switch_program ? ST_RUN : ST_HALTED;
        end
        default: begin
          state_nxt_s = ST_RUN;
        end
      endcase
    end
  end

  assign issue_s = id_valid & ~stall_id & ~flush_ex;

  always_comb begin
    id_entry_s       = '0;
    id_entry_s.valid = 1'b1;
    id_entry_s.dst   = REG_AW_MAX'(id_dst);
    id_entry_s.wen   = id_reg_wen;
    id_entry_s.load  = id_is_load;
  end

  // scoreboard shift; a stalled or flushed ID enters EX as a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_r <= '0;
    end else if (!ext_stall) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        sb_r[k] <= sb_r[k-1];
      end
      sb_r[0] <= issue_s ? id_entry_s : sb_entry_t'('0);
    end else begin
      sb_r <= sb_r;
    end
  end

  // FSM state register, frozen while memory is not ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_RUN;
    end else if (!ext_stall) begin
      state_r <= state_nxt_s;
    end else begin
      state_r <= state_r;
    end
  end

  // saturating stall / flush cycle counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      if (stall_id && !ext_stall && !(&stall_cnt_r)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_ex && !(&flush_cnt_r)) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  always_comb begin
    pipe_valid = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pipe_valid[k] = sb_r[k].valid;
    end
  end

  assign pipe_empty_s = ~|pipe_valid;
  assign halted       = (state_r == ST_HALTED);
  assign stall_cnt    = stall_cnt_r;
  assign flush_cnt    = flush_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three instances (forwarding, stall-only, narrow
// counters) driven from a shared vector table with a queue of expected results.
module tb_pipe_hazard_ctrl;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       iv, rsr, rtr, wen, ld, cf, hr, sw, xs;
  logic [4:0] rs, rt, dst;

  logic       a_spc, a_sid, a_fid, a_fex, a_h;
  logic [2:0] a_frs, a_frt, a_pv;
  logic [15:0] a_sc, a_fc;
  logic       b_spc, b_sid, b_fid, b_fex, b_h;
  logic [2:0] b_frs, b_frt;
  logic [3:0] b_pv;
  logic [15:0] b_sc, b_fc;
  logic       c_spc, c_sid, c_fid, c_fex, c_h;
  logic [2:0] c_frs, c_frt;
  logic [1:0] c_pv, c_sc, c_fc;

  logic [50:0] act_a, act_b, act_c;
  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DEPTH(3), .REG_AW(5), .FWD_EN(1), .CNT_W(16), .SELW(3)) u_dut_a (
    .clk(clk), .rst(rst), .id_valid(iv), .id_rs(rs), .id_rt(rt), .id_rs_read(rsr),
    .id_rt_read(rtr), .id_dst(dst), .id_reg_wen(wen), .id_is_load(ld),
    .change_flow(cf), .halt_req(hr), .switch_program(sw), .ext_stall(xs),
    .stall_pc(a_spc), .stall_id(a_sid), .flush_id(a_fid), .flush_ex(a_fex),
    .fwd_rs_sel(a_frs), .fwd_rt_sel(a_frt), .pipe_valid(a_pv), .halted(a_h),
    .stall_cnt(a_sc), .flush_cnt(a_fc));

  pipe_hazard_ctrl #(.DEPTH(4), .REG_AW(5), .FWD_EN(0), .CNT_W(16), .SELW(3)) u_dut_b (
    .clk(clk), .rst(rst), .id_valid(iv), .id_rs(rs), .id_rt(rt), .id_rs_read(rsr),
    .id_rt_read(rtr), .id_dst(dst), .id_reg_wen(wen), .id_is_load(ld),
    .change_flow(cf), .halt_req(hr), .switch_program(sw), .ext_stall(xs),
    .stall_pc(b_spc), .stall_id(b_sid), .flush_id(b_fid), .flush_ex(b_fex),
    .fwd_rs_sel(b_frs), .fwd_rt_sel(b_frt), .pipe_valid(b_pv), .halted(b_h),
    .stall_cnt(b_sc), .flush_cnt(b_fc));

  pipe_hazard_ctrl #(.DEPTH(2), .REG_AW(5), .FWD_EN(0), .CNT_W(2), .SELW(3)) u_dut_c (
    .clk(clk), .rst(rst), .id_valid(iv), .id_rs(rs), .id_rt(rt), .id_rs_read(rsr),
    .id_rt_read(rtr), .id_dst(dst), .id_reg_wen(wen), .id_is_load(ld),
    .change_flow(cf), .halt_req(hr), .switch_program(sw), .ext_stall(xs),
    .stall_pc(c_spc), .stall_id(c_sid), .flush_id(c_fid), .flush_ex(c_fex),
    .fwd_rs_sel(c_frs), .fwd_rt_sel(c_frt), .pipe_valid(c_pv), .halted(c_h),
    .stall_cnt(c_sc), .flush_cnt(c_fc));

  // bundle layout: {stall_pc,stall_id,flush_id,flush_ex, fwd_rs, fwd_rt, halted, pipe_valid[7:0], stall_cnt, flush_cnt}
  assign act_a = {a_spc, a_sid, a_fid, a_fex, a_frs, a_frt, a_h, 8'(a_pv), a_sc, a_fc};
  assign act_b = {b_spc, b_sid, b_fid, b_fex, b_frs, b_frt, b_h, 8'(b_pv), b_sc, b_fc};
  assign act_c = {c_spc, c_sid, c_fid, c_fex, c_frs, c_frt, c_h, 8'(c_pv), 16'(c_sc), 16'(c_fc)};

  typedef struct {
    string       nm;
    bit          rb;
    int          d;
    logic        iv;
    logic [4:0]  rs;
    logic        rsr;
    logic [4:0]  rt;
    logic        rtr;
    logic [4:0]  dst;
    logic        wen;
    logic        ld;
    logic [3:0]  ctl;
    logic [50:0] exp;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  vec_t cur;

  function automatic vec_t ins(string nm, bit rb, int d, logic v, logic [4:0] s1, logic r1,
                               logic [4:0] s2, logic r2, logic [4:0] dd, logic w, logic l,
                               logic [3:0] ctl);
    vec_t x;
    x.nm = nm; x.rb = rb; x.d = d; x.iv = v; x.rs = s1; x.rsr = r1; x.rt = s2; x.rtr = r2;
    x.dst = dd; x.wen = w; x.ld = l; x.ctl = ctl; x.exp = '0;
    return x;
  endfunction

  function automatic vec_t bub(string nm, int d, logic [3:0] ctl);
    return ins(nm, 1'b0, d, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, ctl);
  endfunction

  function automatic vec_t ex(vec_t v, logic [3:0] c, logic [2:0] frs, logic [2:0] frt,
                              logic h, logic [7:0] pv, logic [15:0] sc, logic [15:0] fc);
    v.exp = {c, frs, frt, h, pv, sc, fc};
    return v;
  endfunction

  function automatic logic [50:0] pick(int d);
    if (d == 0) return act_a;
    else if (d == 1) return act_b;
    else return act_c;
  endfunction

  task automatic check(string nm, logic [50:0] act, logic [50:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got ctl=%b fwd=%0d/%0d halted=%b pv=%b cnt=%0d/%0d, expected ctl=%b fwd=%0d/%0d halted=%b pv=%b cnt=%0d/%0d",
               nm, act[50:47], act[46:44], act[43:41], act[40], act[39:32], act[31:16], act[15:0],
               exp[50:47], exp[46:44], exp[43:41], exp[40], exp[39:32], exp[31:16], exp[15:0]);
    end
  endtask

  task automatic idle_inputs();
    iv = 1'b0; rs = 5'd0; rsr = 1'b0; rt = 5'd0; rtr = 1'b0; dst = 5'd0;
    wen = 1'b0; ld = 1'b0; cf = 1'b0; hr = 1'b0; sw = 1'b0; xs = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drive(vec_t v);
    iv = v.iv; rs = v.rs; rsr = v.rsr; rt = v.rt; rtr = v.rtr; dst = v.dst;
    wen = v.wen; ld = v.ld; {cf, hr, sw, xs} = v.ctl;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    #2;
    check("reset_a", act_a, 51'd0);
    check("reset_b", act_b, 51'd0);

    // forwarding from EX then MEM, WB not forwarded
    tbl.push_back(ex(ins("t1_add_r3", 1'b1, 0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 4'b0000), 4'b0000, 3'd0, 3'd0, 1'b0, 8'h00, 16'd0, 16'd0));
    tbl.push_back(ex(ins("t1_fwd_ex", 1'b0, 0, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0, 4'b0000), 4'b0000, 3'd1, 3'd0, 1'b0, 8'h01, 16'd0, 16'd0));
    tbl.push_back(ex(ins("t1_fwd_mem", 1'b0, 0, 1'b1, 5'd3, 1'b1, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 4'b0000), 4'b0000, 3'd2, 3'd0, 1'b0, 8'h03, 16'd0, 16'd0));
    tbl.push_back(ex(ins("t1_wb_rt_mem", 1'b0, 0, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0, 4'b0000), 4'b0000, 3'd0, 3'd2, 1'b0, 8'h07, 16'd0, 16'd0));
    tbl.push_back(ex(bub("t1_bub1", 0, 4'b0000), 4'b0000, 3'd0, 3'd0, 1'b0, 8'h07, 16'd0, 16'd0));
    tbl.push_back(ex(bub("t1_bub2", 0, 4'b0000), 4'b0000, 3'd0, 3'd0, 1'b0, 8'h06, 16'd0, 16'd0));
    // load-use: one bubble, then forward from MEM
    tbl.push_back(ex(ins("t2_lw_r5", 1'b0, 0, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 4'b0000), 4'b0000, 3'd0, 3'd0, 1'b0, 8'h04, 16'd0, 16'd0));
    tbl.push_back(ex(ins("t2_load_use", 1'b0, 0, 1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 4'b0000), 4'b1101, 3'd1, 3'd0, 1'b0, 8'h01, 16'd0, 16'd0));
    tbl.push_back(ex(ins("t2_after_stall", 1'b0, 0, 1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 4'b0000), 4'b0000, 3'd2, 3'd0, 1'b0, 8'h02, 16'd1, 16'd1));
    tbl.push_back(ex(bub("t2_bub", 0, 4'b0000), 4'b0000, 3'd0, 3'd0, 1'b0, 8'h05, 16'd1, 16'd1));
    // redirect overrides a load-use stall
    tbl.push_back(ex(ins("t4_lw_r7", 1'b0, 0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 4'b0000), 4'b0000, 3'd0, 3'd0, 1'b0, 8'h02, 16'd1, 16'd1));
    tbl.push_back(ex(ins("t4_raw_redirect", 1'b0, 0, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 4'b1000), 4'b0011, 3'd1, 3'd0, 1'b0, 8'h05, 16'd1, 16'd1));
    tbl.push_back(ex(bub("t4_bub", 0, 4'b0000), 4'b0000, 3'd0, 3'd0, 1'b0, 8'h02, 16'd1, 16'd2));
    // no forwarding, DEPTH=4: three stall cycles, r0 never a hazard
    tbl.push_back(ex(ins("t3_prod_r7", 1'b1, 1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 4'b0000), 4'b0000, 3'd0, 3'd0, 1'b0, 8'h00, 16'd0, 16'd0));
    tbl.push_back(ex(ins("t3_stall_ex", 1'b0, 1, 1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 4'b0000), 4'b1101, 3'd0, 3'd0, 1'b0, 8'h01, 16'd0, 16'd0));
    tbl.push_back(ex(ins("t3_stall_mem", 1'b0, 1, 1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 4'b0000), 4'b1101, 3'd0, 3'd0, 1'b0, 8'h02, 16'd1, 16'd1));
    tbl.push_back(ex(ins("t3_stall_s2", 1'b0, 1, 1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 4'b0000), 4'b1101, 3'd0, 3'd0, 1'b0, 8'h04, 16'd2, 16'd2));
    tbl.push_back(ex(ins("t3_issue", 1'b0, 1, 1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 4'b0000), 4'b0000, 3'd0, 3'd0, 1'b0, 8'h08, 16'd3, 16'd3));
    tbl.push_back(ex(ins("t3_wr_r0", 1'b0, 1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 4'b0000), 4'b0000, 3'd0, 3'd0, 1'b0, 8'h01, 16'd3, 16'd3));
    tbl.push_back(ex(ins("t3_rd_r0", 1'b0, 1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1, 1'b0, 4'b0000), 4'b0000, 3'd0, 3'd0, 1'b0, 8'h03, 16'd3, 16'd3));
    // halt with three in flight, drain, halt, program switch
    tbl.push_back(ex(ins("t5_a", 1'b1, 0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 4'b0000), 4'b0000, 3'd0, 3'd0, 1'b0, 8'h00, 16'd0, 16'd0));
    tbl.push_back(ex(ins("t5_b", 1'b0, 0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 4'b0000), 4'b0000, 3'd0, 3'd0, 1'b0, 8'h01, 16'd0, 16'd0));
    tbl.push_back(ex(ins("t5_c_halt", 1'b0, 0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 4'b0100), 4'b0000, 3'd0, 3'd0, 1'b0, 8'h03, 16'd0, 16'd0));
    tbl.push_back(ex(bub("t5_drain0", 0, 4'b0000), 4'b1010, 3'd0, 3'd0, 1'b0, 8'h07, 16'd0, 16'd0));
    tbl.push_back(ex(bub("t5_drain1", 0, 4'b0000), 4'b1010, 3'd0, 3'd0, 1'b0, 8'h06, 16'd0, 16'd0));
    tbl.push_back(ex(bub("t5_drain2", 0, 4'b0000), 4'b1010, 3'd0, 3'd0, 1'b0, 8'h04, 16'd0, 16'd0));
    tbl.push_back(ex(bub("t5_drain_empty", 0, 4'b0000), 4'b1010, 3'd0, 3'd0, 1'b0, 8'h00, 16'd0, 16'd0));
    tbl.push_back(ex(bub("t5_halted", 0, 4'b0000), 4'b1010, 3'd0, 3'd0, 1'b1, 8'h00, 16'd0, 16'd0));
    tbl.push_back(ex(bub("t5_switch", 0, 4'b0010), 4'b1010, 3'd0, 3'd0, 1'b1, 8'h00, 16'd0, 16'd0));
    tbl.push_back(ex(bub("t5_switch_run", 0, 4'b0010), 4'b0011, 3'd0, 3'd0, 1'b0, 8'h00, 16'd0, 16'd0));
    tbl.push_back(ex(bub("t5_run_idle", 0, 4'b0000), 4'b0000, 3'd0, 3'd0, 1'b0, 8'h00, 16'd0, 16'd1));
    // ext_stall freezes a pending load-use hazard for five cycles
    tbl.push_back(ex(ins("t6_lw_r5", 1'b1, 0, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 4'b0000), 4'b0000, 3'd0, 3'd0, 1'b0, 8'h00, 16'd0, 16'd0));
    for (int i = 0; i < 5; i++) begin
      tbl.push_back(ex(ins($sformatf("t6_ext_stall_%0d", i), 1'b0, 0, 1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 4'b0001), 4'b1100, 3'd1, 3'd0, 1'b0, 8'h01, 16'd0, 16'd0));
    end
    tbl.push_back(ex(ins("t6_load_use", 1'b0, 0, 1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 4'b0000), 4'b1101, 3'd1, 3'd0, 1'b0, 8'h01, 16'd0, 16'd0));
    tbl.push_back(ex(ins("t6_issue_halt", 1'b0, 0, 1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 4'b0100), 4'b0000, 3'd2, 3'd0, 1'b0, 8'h02, 16'd1, 16'd1));
    tbl.push_back(ex(bub("t6_drain", 0, 4'b0000), 4'b1010, 3'd0, 3'd0, 1'b0, 8'h05, 16'd1, 16'd1));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rb) do_reset();
      @(negedge clk);
      drive(tbl[i]);
      exp_q.push_back(tbl[i]);
      #2;
      cur = exp_q.pop_front();
      check(cur.nm, pick(cur.d), cur.exp);
    end

    // asynchronous reset while draining
    #1 rst = 1'b0;
    #1 check("t6_rst_in_drain", act_a, 51'd0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #2 check("t6_run_after_rst", act_a, 51'd0);
    @(negedge clk);
    #2 check("t6_run_idle", act_a, 51'd0);

    // 2-bit flush counter saturates at 3 under a held redirect
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cf = 1'b1;
      #2;
      check($sformatf("sat_flush_%0d", i), act_c,
            {4'b0011, 3'd0, 3'd0, 1'b0, 8'd0, 16'd0, (i >= 3) ? 16'd3 : 16'(i)});
    end
    @(negedge clk);
    cf = 1'b0;
    #2 check("sat_flush_hold", act_c, {4'b0000, 3'd0, 3'd0, 1'b0, 8'd0, 16'd0, 16'd3});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
